// File: rtl/rcvr_param_if.sv
// Bus between the serial PHY sampler / host read logic and rcvr_param.
// Handshake: ready=1 means data_out holds a valid head word; reading=1 while
// ready=1 pops that word at the next rising edge; reading while ready=0 is ignored.
interface rcvr_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              data_in;
    logic              reading;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic [CW-1:0]     count;
    logic              overrun;
    logic              parity_err;
    logic [1:0]        dbg_state;

    modport master (
        output data_in,
        output reading,
        input  ready,
        input  data_out,
        input  count,
        input  overrun,
        input  parity_err,
        input  dbg_state
    );

    modport slave (
        input  data_in,
        input  reading,
        output ready,
        output data_out,
        output count,
        output overrun,
        output parity_err,
        output dbg_state
    );
endinterface

// File: rtl/rcvr_param.sv
// Parametrised serial frame receiver: hunts a header, captures a DATA_W body plus
// optional even parity, and queues good words in a small registered FIFO.
module rcvr_param #(
    parameter int               HDR_W     = 8,
    parameter logic [HDR_W-1:0] HDR       = 8'hA5,
    parameter int               DATA_W    = 8,
    parameter bit               MSB_FIRST = 1'b1,
    parameter bit               PARITY_EN = 1'b0,
    parameter int               DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    rcvr_param_if.slave bus
);

    localparam int WIN_W = HDR_W - 1;
    localparam int HCW   = $clog2(HDR_W);
    localparam int BW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [HCW-1:0] HUNT_FULL = HCW'(HDR_W - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [CW-1:0]  CNT_FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_BODY   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIN_W-1:0]  window_q;
    logic [HCW-1:0]    hunt_cnt_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] body_q;
    logic [DATA_W-1:0] body_next;
    logic              par_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overrun_q;
    logic              parity_err_q;

    logic              hdr_match;
    logic              last_body;
    logic [BW-1:0]     body_idx;
    logic              frame_done;
    logic              frame_good;
    logic [DATA_W-1:0] frame_word;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop_full;

    // Only HDR_W-1 past bits are kept; the current bit completes the header.
    assign hdr_match = (state_q == S_HUNT) &&
                       ({window_q, bus.data_in} == HDR) &&
                       (hunt_cnt_q == HUNT_FULL);
    assign last_body = (state_q == S_BODY) && (bit_cnt_q == BIT_LAST);
    assign body_idx  = MSB_FIRST ? (BIT_LAST - bit_cnt_q) : bit_cnt_q;

    always_comb begin
        body_next = body_q;
        if (state_q == S_BODY) begin
            body_next[body_idx] = bus.data_in;
        end
    end

    always_comb begin
        frame_done = 1'b0;
        frame_good = 1'b0;
        frame_word = body_q;
        if (PARITY_EN) begin
            if (state_q == S_PARITY) begin
                frame_done = 1'b1;
                frame_good = ~(par_q ^ bus.data_in);
            end
        end else if (last_body) begin
            frame_done = 1'b1;
            frame_good = 1'b1;
            frame_word = body_next;
        end
    end

    assign full      = (count_q == CNT_FULL);
    assign pop       = bus.reading && (count_q != '0);
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push      = frame_done && frame_good && (!full || pop);
    assign drop_full = frame_done && frame_good && full && !pop;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HUNT: begin
                if (hdr_match) begin
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (last_body) begin
                    state_d = PARITY_EN ? S_PARITY : S_HUNT;
                end
            end
            S_PARITY: begin
                state_d = S_HUNT;
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    // Header window is live only while staying in HUNT, so no bit outside the
    // hunt (body, parity, or the matching header) ever seeds the next header.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            window_q   <= '0;
            hunt_cnt_q <= '0;
        end else if (state_q == S_HUNT && state_d == S_HUNT) begin
            window_q <= WIN_W'({window_q, bus.data_in});
            if (hunt_cnt_q != HUNT_FULL) begin
                hunt_cnt_q <= hunt_cnt_q + HCW'(1);
            end
        end else begin
            window_q   <= '0;
            hunt_cnt_q <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q <= '0;
            body_q    <= '0;
            par_q     <= 1'b0;
        end else begin
            body_q <= body_next;
            if (state_q == S_BODY) begin
                bit_cnt_q <= last_body ? '0 : (bit_cnt_q + BW'(1));
                par_q     <= par_q ^ bus.data_in;
            end else begin
                bit_cnt_q <= '0;
                par_q     <= 1'b0;
            end
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= frame_word;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Setting wins over the read-side clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (drop_full) begin
                overrun_q <= 1'b1;
            end else if (bus.reading) begin
                overrun_q <= 1'b0;
            end
            parity_err_q <= frame_done && !frame_good;
        end
    end

    assign bus.ready      = (count_q != '0);
    assign bus.data_out   = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign bus.count      = count_q;
    assign bus.overrun    = overrun_q;
    assign bus.parity_err = parity_err_q;
    assign bus.dbg_state  = state_q;

endmodule
